// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving a single-port RAM with registered read address.
// Owns the pointers, arbitrates the RAM port round-robin and registers RAM read data.
module ram_fifo_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wnr,
    input  logic [WIDTH-1:0]  ram_q,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              last_grant_q, last_grant_d;

    logic cnt_full;
    logic cnt_zero;
    logic wr_req;
    logic rd_req;
    logic wr_grant;
    logic rd_grant;

    // Requests and round-robin grant of the single RAM port
    always_comb begin
        cnt_full = (ram_cnt_q == CNT_W'(DEPTH));
        cnt_zero = (ram_cnt_q == '0);
        wr_req   = in_valid && !cnt_full;
        rd_req   = !cnt_zero && !rd_pend_q && (!out_valid_q || out_ready);
        wr_grant = wr_req && (!rd_req || last_grant_q);
        rd_grant = rd_req && (!wr_req || !last_grant_q);
    end

    // Idle cycles park the address on rd_ptr; ram_q is ignored unless a read is pending
    always_comb begin
        ram_wnr  = wr_grant;
        ram_addr = wr_grant ? wr_ptr_q : rd_ptr_q;
        in_ready = wr_grant;
        full     = cnt_full;
        empty    = cnt_zero && !rd_pend_q && !out_valid_q;
    end

    assign ram_data  = in_data;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state: pointer/count update on grant, capture and drain of output stage
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_cnt_d    = ram_cnt_q;
        rd_pend_d    = rd_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;

        if (wr_grant) begin
            wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
            ram_cnt_d    = ram_cnt_q + CNT_W'(1);
            last_grant_d = 1'b0;
        end else if (rd_grant) begin
            rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
            ram_cnt_d    = ram_cnt_q - CNT_W'(1);
            rd_pend_d    = 1'b1;
            last_grant_d = 1'b1;
        end

        if (rd_pend_q) begin
            out_data_d  = ram_q;
            out_valid_d = 1'b1;
            rd_pend_d   = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            rd_pend_q    <= rd_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a registered-read-address RAM model, DEPTH=4.
module tb_ram_fifo_ctrl;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wnr;
    logic [WIDTH-1:0]  ram_q;
    logic              full;
    logic              empty;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] rx[$];

    ram_fifo_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_wnr(ram_wnr), .ram_q(ram_q),
        .full(full), .empty(empty)
    );

    // RAM model: write on edge, otherwise load the read address register
    logic [WIDTH-1:0]  mem [4];
    logic [ADDR_W-1:0] addr_reg;
    always @(posedge clk) begin
        if (ram_wnr) mem[ram_addr] <= ram_data;
        else         addr_reg      <= ram_addr;
    end
    assign ram_q = mem[addr_reg];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample at the falling edge; record every output handshake
    task automatic settle();
        @(negedge clk);
        if (out_valid && out_ready) rx.push_back(out_data);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            settle();
            acc = in_ready;
            advance();
            if (acc) break;
        end
        in_valid = 1'b0;
        check_eq("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_empty();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            settle();
            done = empty;
            advance();
            if (done) break;
        end
        check_eq("wait_empty", 32'(done), 32'd1);
    endtask

    task automatic check_rx(input string tag, input logic [WIDTH-1:0] exp[$]);
        logic [31:0] got;
        check_eq({tag, "_count"}, 32'(rx.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF;
            check_eq($sformatf("%s_word%0d", tag, i), got, 32'(exp[i]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_ram_wnr", 32'(ram_wnr), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        rx.delete();
    endtask

    initial begin
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] d;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2;
        do_reset();

        // Single word: accepted, visible two edges later, then consumed
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        settle();
        check_eq("single_in_ready", 32'(in_ready), 32'd1);
        check_eq("single_wnr", 32'(ram_wnr), 32'd1);
        check_eq("single_addr", 32'(ram_addr), 32'd0);
        advance();
        in_valid = 1'b0;
        settle();
        check_eq("single_ov_e0", 32'(out_valid), 32'd0);
        check_eq("single_empty_e0", 32'(empty), 32'd0);
        advance();
        settle();
        check_eq("single_ov_e1", 32'(out_valid), 32'd0);
        advance();
        settle();
        check_eq("single_ov_e2", 32'(out_valid), 32'd1);
        check_eq("single_od_e2", 32'(out_data), 32'hA5);
        advance();
        settle();
        check_eq("single_empty_e3", 32'(empty), 32'd1);
        check_eq("single_ov_e3", 32'(out_valid), 32'd0);
        advance();
        exp_q = '{8'hA5};
        check_rx("single_rx", exp_q);
        rx.delete();

        // Fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        settle();
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_ov", 32'(out_valid), 32'd1);
        check_eq("fill_od", 32'(out_data), 32'h10);
        advance();

        // Backpressure hold with 0x15 waiting
        in_valid = 1'b1;
        in_data  = 8'h15;
        for (int c = 0; c < 10; c++) begin
            settle();
            check_eq($sformatf("hold_in_ready%0d", c), 32'(in_ready), 32'd0);
            check_eq($sformatf("hold_full%0d", c), 32'(full), 32'd1);
            check_eq($sformatf("hold_od%0d", c), 32'(out_data), 32'h10);
            check_eq($sformatf("hold_wnr%0d", c), 32'(ram_wnr), 32'd0);
            check_eq($sformatf("hold_addr%0d", c), 32'(ram_addr), 32'd2);
            advance();
        end

        // Drain while pushing, pointers wrap
        out_ready = 1'b1;
        push(8'h15);
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        wait_empty();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                  8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        check_rx("drain_rx", exp_q);

        // Contention from reset: port alternates write/read
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d         = 8'h30;
        for (int c = 0; c < 10; c++) begin
            in_data = d;
            settle();
            check_eq($sformatf("cont_wnr%0d", c), 32'(ram_wnr), 32'((c % 2) == 0));
            check_eq($sformatf("cont_in_ready%0d", c), 32'(in_ready), 32'((c % 2) == 0));
            if (in_ready) d = d + 8'd1;
            advance();
        end
        in_valid = 1'b0;
        wait_empty();
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        check_rx("cont_rx", exp_q);

        // Reset mid-operation: 3 words in RAM and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        out_ready = 1'b1;
        settle();
        check_eq("midrst_full", 32'(full), 32'd1);
        check_eq("midrst_wnr", 32'(ram_wnr), 32'd0);
        advance();
        out_ready = 1'b0;
        #1;
        do_reset();
        out_ready = 1'b1;
        push(8'h5A);
        wait_empty();
        exp_q = '{8'h5A};
        check_rx("midrst_rx", exp_q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Valid/ready FIFO controller that drives a single-port, registered-read-address RAM of the team's standard form. The RAM has one address port, a write-not-read select, writes on the clock edge and presents `q = ram[addr_reg]`, with `addr_reg` loaded on non-write edges. This block sits directly upstream of that RAM. It owns the write and read pointers, arbitrates the single RAM port between the producer and the consumer, and captures RAM read data into a registered output stage.

## Interface
- `WIDTH`, default 8: data word width; must match the RAM `width`.
- `ADDR_W`, default 6: RAM address width; must match the RAM `address`. `DEPTH = 2**ADDR_W`.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, WIDTH: producer word.
- `in_valid`, input, 1: producer has a word.
- `in_ready`, output, 1: word accepted this cycle when `in_valid && in_ready`.
- `out_data`, output, WIDTH: registered output word.
- `out_valid`, output, 1: `out_data` holds a word.
- `out_ready`, input, 1: consumer takes the word this cycle when `out_valid && out_ready`.
- `ram_data`, output, WIDTH: to RAM `data`; equals `in_data`.
- `ram_addr`, output, ADDR_W: to RAM `addr`.
- `ram_wnr`, output, 1: to RAM `wnr`; 1 means write.
- `ram_q`, input, WIDTH: from RAM `q`.
- `full`, output, 1: RAM holds DEPTH words.
- `empty`, output, 1: no word anywhere in the block, i.e. RAM, in-flight read and output register all empty.

## Operation
- State:
  - `wr_ptr` and `rd_ptr`: ADDR_W bits each; they wrap modulo DEPTH with no special logic.
  - `ram_cnt`: ADDR_W+1 bits, range 0..DEPTH.
  - `rd_pend`: 1 bit.
  - `out_valid` and `out_data` registers.
  - `last_grant`: 1 bit; 0 = write granted last, 1 = read granted last.
- Requests, evaluated combinationally each cycle:
  - `wr_req = in_valid && ram_cnt != DEPTH`.
  - `rd_req = ram_cnt != 0 && !rd_pend && (!out_valid || out_ready)`.
- Arbitration for the single RAM port:
  - Only one request: it is granted.
  - Both request: grant the side that was not granted last (round-robin via `last_grant`).
  - `last_grant` updates only on a grant.
- Write grant:
  - Combinational outputs: `ram_wnr=1`, `ram_addr=wr_ptr`, `in_ready=1`.
  - At the edge: `wr_ptr+1`, `ram_cnt+1`.
- Read grant:
  - Combinational outputs: `ram_wnr=0`, `ram_addr=rd_ptr`.
  - At the edge: `rd_ptr+1`, `ram_cnt-1`, `rd_pend<=1`.
- No grant: `ram_wnr=0`, `ram_addr=rd_ptr`.
  - This is harmless: it reloads the RAM address register, and `ram_q` is only consumed when `rd_pend=1`.
- `in_ready = wr_grant`. It depends combinationally on `in_valid`, `out_ready` and state.
  - The producer must not make `in_valid` depend on `in_ready`.
- Data capture:
  - In a cycle with `rd_pend=1`, `ram_q` is valid. At the edge: `out_data<=ram_q`, `out_valid<=1`, `rd_pend<=0`.
  - The read-issue rule guarantees the output register is free or being drained at that edge, so no word is ever overwritten.
- Output drain: `out_valid && out_ready` with no capture in the same cycle clears `out_valid`.
- Counter width rule: `ram_cnt` never increments and decrements in the same cycle, because the port is exclusive.
- Status outputs:
  - `full = (ram_cnt == DEPTH)`.
  - `empty = (ram_cnt == 0) && !rd_pend && !out_valid`.
- Total capacity is DEPTH+1 words: DEPTH in the RAM plus the output register.
- RAM contents are not cleared by reset. Pointers alone define occupancy.

## Timing
- Reset (asynchronous assert, any cycle including mid-transfer):
  - Register values: `wr_ptr=0`, `rd_ptr=0`, `ram_cnt=0`, `rd_pend=0`, `out_valid=0`, `out_data=0`, `last_grant=1`. With `last_grant=1`, a write wins the first conflict.
  - Resulting outputs: `in_ready=0`, `full=0`, `empty=1`, `ram_wnr=0`, `ram_addr=0`.
  - All in-flight and stored words are dropped.
- Deassertion is synchronised externally. The first grant is possible in the first cycle after release.
- Latency from an empty FIFO with no contention:
  - Word accepted at edge E0.
  - Read issued in the cycle after E0 (edge E1).
  - Captured at edge E2; `out_valid=1` from E2.
  - Two edges from acceptance to output.
- Throughput:
  - Writes: one per cycle while uncontended.
  - Reads: at most one per two cycles, because reads are blocked while `rd_pend=1`.
  - When both sides are saturated, the round-robin alternates the port.
- Full: `in_ready=0` whenever `ram_cnt==DEPTH`, regardless of `in_valid`.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Test plan
All scenarios use WIDTH=8 and ADDR_W=2 (DEPTH=4), with the RAM model attached.

- **Single word:** push 0xA5 into an empty FIFO, with `out_ready=1`.
  - `in_ready=1` in the cycle 0xA5 is presented; `out_valid` rises two edges after acceptance with `out_data=0xA5`.
  - `empty` returns to 1 after the consume edge.
- **Fill to full:** hold `out_ready=0` and push 0x10..0x15.
  - 0x10 moves to the output register.
  - 0x11..0x14 fill the RAM; `full=1`.
  - 0x15 sees `in_ready=0` until `out_ready` rises.
- **Drain with wrap:** drain the full state from the fill scenario while pushing 0x20..0x27.
  - Output order is exactly 0x10..0x14, then 0x15, then 0x20..0x27.
  - Pointers wrap twice with no loss or duplication.
- **Contention:** hold `in_valid=1` and `out_ready=1` continuously.
  - `ram_wnr` alternates 1,0,1,0 on conflict cycles.
  - First conflict goes to the write after reset.
  - Data order is preserved.
- **Reset mid-operation:** with 3 words stored and `rd_pend=1`, pulse `rst_n` low asynchronously between edges.
  - `out_valid=0`, `empty=1`, `full=0` immediately.
  - A subsequent push of 0x5A emerges as the first output.
- **Backpressure hold:** `out_valid=1` with `out_ready=0` for 10 cycles.
  - `out_data` stays stable.
  - No read is issued.
  - `ram_cnt` does not decrement.
